// File: rtl/mysystem_pio_pkg.sv
// Shared register map for the multi-channel output PIO bank.
package mysystem_pio_pkg;
  localparam logic [1:0] REG_SHADOW = 2'd0;
  localparam logic [1:0] REG_SET    = 2'd1;
  localparam logic [1:0] REG_CLEAR  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int CTRL_PEND = 0;
  localparam int CTRL_IMM  = 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PEND = 1'b1;
endpackage

// File: rtl/mysystem_pio_channel.sv
// One PIO channel: shadow register, committed output and the pending-commit FSM.
module mysystem_pio_channel
  import mysystem_pio_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we_shadow,
  input  logic              i_we_set,
  input  logic              i_we_clr,
  input  logic              i_we_ctrl,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_ctrl_pend,
  input  logic              i_ctrl_imm,
  input  logic              i_strobe,
  output logic [DATA_W-1:0] o_shadow,
  output logic [DATA_W-1:0] o_out,
  output logic              o_pend,
  output logic              o_done
);
  logic [DATA_W-1:0] r_shadow, r_out;
  logic [0:0]        r_state;
  logic              r_done;
  logic              w_commit;

  // Strobe only honours a request that was already pending before this edge.
  assign w_commit = (i_strobe && r_state == ST_PEND) || (i_we_ctrl && i_ctrl_imm);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shadow <= RESET_VAL;
      r_out    <= RESET_VAL;
      r_state  <= ST_IDLE;
      r_done   <= 1'b0;
    end else begin
      if (i_we_shadow)   r_shadow <= i_wdata;
      else if (i_we_set) r_shadow <= r_shadow | i_wdata;
      else if (i_we_clr) r_shadow <= r_shadow & ~i_wdata;

      if (w_commit) r_out <= r_shadow;
      r_done <= w_commit;

      if (i_we_ctrl) begin
        if (i_ctrl_imm)       r_state <= ST_IDLE;
        else if (i_ctrl_pend) r_state <= ST_PEND;
        else                  r_state <= ST_IDLE;
      end else if (i_strobe && r_state == ST_PEND) begin
        r_state <= ST_IDLE;
      end
    end
  end

  assign o_shadow = r_shadow;
  assign o_out    = r_out;
  assign o_pend   = (r_state == ST_PEND);
  assign o_done   = r_done;
endmodule

// File: rtl/mysystem_pio_bank.sv
// Avalon-MM multi-channel output PIO: decode, registered read mux, output concatenation.
module mysystem_pio_bank
  import mysystem_pio_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                NUM_CH    = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               ADDR_W    = $clog2(NUM_CH) + 2
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          address,
  input  logic                       chipselect,
  input  logic                       write_n,
  input  logic                       read_n,
  input  logic [31:0]                writedata,
  output logic [31:0]                readdata,
  input  logic                       commit_strobe,
  output logic [NUM_CH*DATA_W-1:0]   out_port,
  output logic [NUM_CH-1:0]          commit_done
);
  logic                          w_wr, w_rd;
  logic [ADDR_W+1:0]             w_addr_x;
  logic [ADDR_W-1:0]             w_ch;
  logic [1:0]                    w_reg;
  logic                          w_ch_ok;
  logic [NUM_CH-1:0][DATA_W-1:0] w_shadow;
  logic [NUM_CH-1:0]             w_pend;
  logic [31:0]                   w_rd_val;
  logic [31:0]                   r_rdata;
  logic                          w_unused;

  assign w_wr     = chipselect && !write_n;
  assign w_rd     = chipselect && !read_n;
  // Widened so the channel field stays a legal slice even when NUM_CH == 1.
  assign w_addr_x = {2'b00, address};
  assign w_ch     = w_addr_x[ADDR_W+1:2];
  assign w_reg    = address[1:0];
  assign w_ch_ok  = (w_ch < ADDR_W'(NUM_CH));
  assign w_unused = ^writedata;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic w_sel;
    assign w_sel = w_wr && w_ch_ok && (w_ch == ADDR_W'(c));
    mysystem_pio_channel #(.DATA_W(DATA_W), .RESET_VAL(RESET_VAL)) u_ch (
      .i_clk       (clk),
      .i_rst_n     (reset_n),
      .i_we_shadow (w_sel && w_reg == REG_SHADOW),
      .i_we_set    (w_sel && w_reg == REG_SET),
      .i_we_clr    (w_sel && w_reg == REG_CLEAR),
      .i_we_ctrl   (w_sel && w_reg == REG_CTRL),
      .i_wdata     (writedata[DATA_W-1:0]),
      .i_ctrl_pend (writedata[CTRL_PEND]),
      .i_ctrl_imm  (writedata[CTRL_IMM]),
      .i_strobe    (commit_strobe),
      .o_shadow    (w_shadow[c]),
      .o_out       (out_port[c*DATA_W +: DATA_W]),
      .o_pend      (w_pend[c]),
      .o_done      (commit_done[c])
    );
  end

  always_comb begin
    w_rd_val = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (w_ch_ok && w_ch == ADDR_W'(c)) begin
        if (w_reg == REG_SHADOW)    w_rd_val = 32'(w_shadow[c]);
        else if (w_reg == REG_CTRL) w_rd_val = {31'd0, w_pend[c]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)  r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rd_val;
  end

  assign readdata = r_rdata;
endmodule

// File: tb/tb_mysystem_pio_bank.sv
// Directed bench for mysystem_pio_bank: 3 channels of 8 bits, nonzero reset value.
module tb_mysystem_pio_bank;
  localparam int         DATA_W = 8;
  localparam int         NUM_CH = 3;
  localparam logic [7:0] RV     = 8'h3C;

  logic                     clk = 1'b0;
  logic                     reset_n = 1'b0;
  logic [3:0]               address = '0;
  logic                     chipselect = 1'b0, write_n = 1'b1, read_n = 1'b1;
  logic [31:0]              writedata = '0;
  logic [31:0]              readdata;
  logic                     commit_strobe = 1'b0;
  logic [NUM_CH*DATA_W-1:0] out_port;
  logic [NUM_CH-1:0]        commit_done;

  int n_chk = 0, n_fail = 0;

  mysystem_pio_bank #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .RESET_VAL(RV)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .read_n(read_n), .writedata(writedata), .readdata(readdata),
    .commit_strobe(commit_strobe), .out_port(out_port), .commit_done(commit_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One bus cycle, entered and left at a negedge; effects visible on return.
  task automatic bus(input bit w, input bit r, input int ch, input int rg,
                     input logic [31:0] d, input bit s);
    address       = 4'((ch << 2) | rg);
    chipselect    = w | r;
    write_n       = ~w;
    read_n        = ~r;
    writedata     = d;
    commit_strobe = s;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1; commit_strobe = 1'b0;
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    bus(1'b1, 1'b0, ch, rg, d, 1'b0);
  endtask

  task automatic rd_chk(input string tag, input int ch, input int rg, input logic [31:0] exp);
    bus(1'b0, 1'b1, ch, rg, 32'h0, 1'b0);
    chk(tag, readdata, exp);
  endtask

  function automatic logic [7:0] outf(input int c);
    return out_port[c*DATA_W +: DATA_W];
  endfunction

  initial begin
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    chk("rst_out0", 32'(outf(0)), 32'(RV));
    chk("rst_out1", 32'(outf(1)), 32'(RV));
    chk("rst_out2", 32'(outf(2)), 32'(RV));
    chk("rst_done", 32'(commit_done), 32'h0);
    chk("rst_rdata", readdata, 32'h0);
    rd_chk("rst_ctrl0", 0, 3, 32'h0);
    rd_chk("rst_shadow1", 1, 0, 32'(RV));

    // deferred commit on ch1
    wr(1, 0, 32'hA5);
    wr(1, 3, 32'h1);
    chk("def_out_hold", 32'(outf(1)), 32'(RV));
    rd_chk("def_ctrl_pend", 1, 3, 32'h1);
    bus(1'b0, 1'b0, 0, 0, 32'h0, 1'b1);
    chk("def_out", 32'(outf(1)), 32'hA5);
    chk("def_done", 32'(commit_done), 32'h2);
    @(negedge clk);
    chk("def_done_1cyc", 32'(commit_done), 32'h0);
    rd_chk("def_ctrl_clr", 1, 3, 32'h0);

    // set/clear then immediate commit on ch0; upper bits ignored
    wr(0, 0, 32'h1234_56F0);
    wr(0, 1, 32'h0F);
    wr(0, 2, 32'h81);
    rd_chk("sc_shadow", 0, 0, 32'h7E);
    wr(0, 3, 32'h2);
    chk("imm_out", 32'(outf(0)), 32'h7E);
    chk("imm_done", 32'(commit_done), 32'h1);
    rd_chk("imm_ctrl", 0, 3, 32'h0);

    // CTRL pend request coinciding with strobe: no commit yet
    wr(1, 0, 32'h5A);
    bus(1'b1, 1'b0, 1, 3, 32'h1, 1'b1);
    chk("same_out_hold", 32'(outf(1)), 32'hA5);
    chk("same_no_done", 32'(commit_done), 32'h0);
    rd_chk("same_pend", 1, 3, 32'h1);
    bus(1'b0, 1'b0, 0, 0, 32'h0, 1'b1);
    chk("same_next_out", 32'(outf(1)), 32'h5A);
    chk("same_next_done", 32'(commit_done), 32'h2);

    // shadow write during commit: out takes pre-write shadow
    wr(0, 0, 32'h11);
    wr(0, 3, 32'h1);
    bus(1'b1, 1'b0, 0, 0, 32'h22, 1'b1);
    chk("wdc_out", 32'(outf(0)), 32'h11);
    chk("wdc_done", 32'(commit_done), 32'h1);
    rd_chk("wdc_shadow", 0, 0, 32'h22);
    rd_chk("wdc_ctrl", 0, 3, 32'h0);

    // immediate commit together with strobe: single pulse
    wr(1, 0, 32'h66);
    wr(1, 3, 32'h1);
    bus(1'b1, 1'b0, 1, 3, 32'h2, 1'b1);
    chk("imms_out", 32'(outf(1)), 32'h66);
    chk("imms_done", 32'(commit_done), 32'h2);
    bus(1'b0, 1'b0, 0, 0, 32'h0, 1'b1);
    chk("imms_no_second", 32'(commit_done), 32'h0);

    // cancel on ch2
    wr(2, 0, 32'h77);
    wr(2, 3, 32'h1);
    wr(2, 3, 32'h0);
    bus(1'b0, 1'b0, 0, 0, 32'h0, 1'b1);
    chk("cancel_out", 32'(outf(2)), 32'(RV));
    chk("cancel_done", 32'(commit_done), 32'h0);

    // out-of-range channel
    wr(3, 0, 32'hFF);
    wr(3, 3, 32'h2);
    chk("oor_out0", 32'(outf(0)), 32'h11);
    chk("oor_out1", 32'(outf(1)), 32'h66);
    chk("oor_out2", 32'(outf(2)), 32'(RV));
    rd_chk("oor_pre", 0, 0, 32'h22);
    rd_chk("oor_shadow", 3, 0, 32'h0);
    rd_chk("pre_hold", 2, 0, 32'h77);
    @(negedge clk);
    chk("rd_hold", readdata, 32'h77);

    // reset discards a pending commit
    wr(2, 3, 32'h1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    chk("rst2_out0", 32'(outf(0)), 32'(RV));
    chk("rst2_rdata", readdata, 32'h0);
    bus(1'b0, 1'b0, 0, 0, 32'h0, 1'b1);
    chk("rst2_no_commit", 32'(commit_done), 32'h0);
    rd_chk("rst2_shadow2", 2, 0, 32'(RV));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mysystem_pio_bank.md
# mysystem_pio_bank

Parametrised multi-channel Avalon-MM output PIO for the Nios system: NUM_CH independent output registers of DATA_W bits, each with a software-writable shadow register, atomic bit set/clear, and commit either deferred to an external `commit_strobe` or applied immediately. It replaces the single-register column/row address PIOs. Downstream camera/frame logic therefore sees multi-field updates change together, typically on frame sync, never half-written.

## Interface
- DATA_W, 32, width of each channel register (1..32)
- NUM_CH, 4, channel count (1..16)
- RESET_VAL, 0, reset value of every shadow and output register (DATA_W bits)
- ADDR_W, derived = clog2(NUM_CH)+2, word address width; not overridable

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset; synchronous, active-low
- address  in  ADDR_W  word address: {channel, reg}; reg = address[1:0]
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- writedata  in  32  write data; bits above DATA_W ignored
- readdata  out  32  read data, fixed read latency 1
- commit_strobe  in  1  single-cycle pulse (e.g. frame sync); commits all pending channels
- out_port  out  NUM_CH*DATA_W  committed outputs; channel c at [c*DATA_W +: DATA_W]
- commit_done  out  NUM_CH  one-cycle pulse per channel whose output was loaded

## Operation
- Write = chipselect & ~write_n. Read = chipselect & ~read_n. Channel index ≥ NUM_CH: writes ignored, reads return 0.
- reg 0 SHADOW: write loads shadow. Read returns shadow, zero-extended.
- reg 1 SET: shadow ← shadow | wdata. Reads return 0.
- reg 2 CLEAR: shadow ← shadow & ~wdata. Reads return 0.
- reg 3 CTRL, write: bit1 = 1 → immediate commit (out ← shadow), pending ← 0. Otherwise pending ← bit0; writing 0 cancels a pending commit.
- reg 3 CTRL, read: bit0 = pending. Bits [31:1] read 0.
- Commit: on commit_strobe, every channel whose pending was already 1 at that clock edge does out ← shadow and pending ← 0, and its commit_done pulses.
- Per channel, pending is a 2-state FSM, IDLE ↔ PENDING. It leaves PENDING on strobe, immediate commit, or cancel.

## Timing
- Reset (reset_n low at a clk edge): shadow = out_port = RESET_VAL, pending = 0, readdata = 0, commit_done = 0. Reset during a pending commit discards the commit.
- Register writes take effect at the edge of the write cycle; out_port changes one edge after a commit cycle.
- readdata is valid the cycle after the read strobe and holds until the next read. The value reflects state before any same-cycle write.
- CTRL write with bit0 = 1 in the same cycle as commit_strobe: no commit at that strobe. Pending becomes 1 and waits for the next strobe.
- Shadow/SET/CLEAR write in the same cycle as a commit: out takes the pre-write shadow; shadow takes the new value.
- Immediate commit in the same cycle as commit_strobe: a single commit, a single commit_done pulse.
- commit_strobe with no pending channels: no effect.
- commit_strobe held high for several cycles: acts per cycle, with no extra effect once pending is cleared.

## Structure
- Package mysystem_pio_pkg: register offsets REG_SHADOW = 0, REG_SET = 1, REG_CLEAR = 2, REG_CTRL = 3; CTRL bit positions CTRL_PEND = 0, CTRL_IMM = 1.
- Sub-module mysystem_pio_channel: shadow, out, and pending FSM for one channel; the top generates NUM_CH of them.
- Top level holds address decode, the registered read mux, and out_port concatenation.

## Test plan
- Reset: drive reset_n low for 2 clks → every out_port field = RESET_VAL, commit_done = 0, and a read of ch0 reg 3 returns 0.
- Deferred commit: write ch1 SHADOW = 0xA5, then ch1 CTRL = 0x1 → out_port ch1 unchanged and CTRL reads 1. On the next commit_strobe, ch1 out = 0xA5, commit_done[1] pulses for one cycle, and CTRL reads 0.
- Set/clear: write SHADOW = 0xF0, SET 0x0F, CLEAR 0x81 → SHADOW reads 0x7E. Then CTRL = 0x2 → out = 0x7E on the next cycle with no strobe needed.
- Same-cycle request and strobe: CTRL = 0x1 coincides with commit_strobe → no commit. The following strobe commits.
- Write during commit: ch0 pending with shadow 0x11; SHADOW = 0x22 coincides with commit_strobe → out = 0x11 and shadow reads 0x22.
- Cancel and out-of-range access: pending on ch2, then CTRL = 0 → the strobe does not change ch2. A write to channel index NUM_CH has no effect, and a read of it returns 0.
